// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int          INSTR_W     = 32;
  localparam logic [31:0] PC_INC      = 32'd4;
  localparam logic [31:0] PC_READ_OFS = 32'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, decode handshake, branch redirect and state debug.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr;
  logic [31:0]  instr_pc;
  logic [31:0]  pc_plus8;
  logic         pcsrc;
  logic [31:0]  branch_target;
  fetch_state_t dbg_state;

  // An instruction transfers on every cycle where instr_valid and instr_ready are both high;
  // once instr_valid rises, instr/instr_pc/pc_plus8 hold until that transfer or a pcsrc flush.
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus8, dbg_state,
    input  imem_rvalid, imem_rdata, instr_ready, pcsrc, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus8, dbg_state,
    output imem_rvalid, imem_rdata, instr_ready, pcsrc, branch_target
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with registered storage; flush wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  fetch_entry_t           i_wdata,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one imem request in flight and buffers
// responses for decode. Defining FETCH_PERF_EN adds saturating bubble and flush counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_bubble_cnt,
  output logic [31:0]  perf_flush_cnt
`endif
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] L_DEPTH = (CW+1)'(DEPTH);

  fetch_state_t  r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_out_pc;
  fetch_entry_t  w_head;
  fetch_entry_t  w_wdata;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_count_next;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_room;
  logic          w_can_issue;
  logic          w_issue;

  // A redirect cancels both the pop and the push: everything fetched so far is younger.
  assign w_pop        = ~w_empty & bus.instr_ready & ~bus.pcsrc;
  assign w_push       = (r_state == WAIT) & bus.imem_rvalid & ~bus.pcsrc;
  assign w_count_next = {1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_pop);
  assign w_room       = w_push ? (w_count_next < L_DEPTH) : (~w_full | w_pop);
  assign w_can_issue  = (r_state == IDLE) | ((r_state == WAIT) & bus.imem_rvalid);
  assign w_issue      = reset & ~bus.pcsrc & w_can_issue & w_room;
  assign w_wdata      = '{pc: r_out_pc, instr: bus.imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.pcsrc),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_out_pc <= '0;
    end else if (bus.pcsrc) begin
      r_pc <= {bus.branch_target[31:2], 2'b00};
      // A response arriving with the redirect is consumed here; otherwise DROP absorbs it later.
      if (r_state != IDLE) r_state <= bus.imem_rvalid ? IDLE : DROP;
    end else if (w_issue) begin
      r_state  <= WAIT;
      r_out_pc <= r_pc;
      r_pc     <= r_pc + PC_INC;
    end else if (bus.imem_rvalid) begin
      r_state <= IDLE;
    end
  end

  assign bus.imem_req    = w_issue;
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = ~w_empty;
  assign bus.instr       = w_head.instr;
  assign bus.instr_pc    = w_head.pc;
  assign bus.pc_plus8    = w_head.pc + PC_READ_OFS;
  assign bus.dbg_state   = r_state;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_bubble_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (bus.instr_ready & w_empty & (perf_bubble_cnt != '1))
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (bus.pcsrc & (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an expected-PC queue models the instruction stream decode should see,
// a one-slot memory model answers requests with addr ^ 32'hE000_0000 after a chosen latency.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XOR_K    = 32'hE000_0000;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  fetch_unit_if bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_bubble_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_bubble_cnt (perf_bubble_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: PCs decode should see, oldest first, plus the in-flight request.
  logic [31:0] exp_q[$];
  logic [31:0] m_next;
  logic [31:0] m_out_pc;
  logic        m_out;
  logic        m_stale;
  logic        m_pop;
  logic        m_push;
  logic        m_req;
  int          bubbles;
  int          flushes;

  // Memory model: one pending request answered mem_lat cycles after issue.
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_due;
  int          mem_lat = 1;

  task automatic do_reset();
    reset             = 1'b0;
    bus.instr_ready   = 1'b0;
    bus.pcsrc         = 1'b0;
    bus.branch_target = 32'h0;
    bus.imem_rvalid   = 1'b0;
    bus.imem_rdata    = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    m_next   = RESET_PC;
    m_out_pc = 32'h0;
    m_out    = 1'b0;
    m_stale  = 1'b0;
    mem_pend = 1'b0;
    cyc      = 0;
    bubbles  = 0;
    flushes  = 0;
  endtask

  // ---------------- driver tasks ----------------
  // Drive memory response for this cycle, settle to the negedge, predict this cycle's outcome.
  task automatic sample();
    bus.imem_rvalid = mem_pend && (cyc >= mem_due);
    bus.imem_rdata  = bus.imem_rvalid ? (mem_addr ^ XOR_K) : 32'($urandom);
    @(negedge clk);
    if (bus.pcsrc) begin
      m_pop  = 1'b0;
      m_push = 1'b0;
      m_req  = 1'b0;
    end else begin
      m_pop  = bus.instr_ready && (exp_q.size() > 0);
      m_push = bus.imem_rvalid && m_out && !m_stale;
      m_req  = (!m_out || m_push) && ((exp_q.size() + int'(m_push) - int'(m_pop)) < DEPTH);
    end
  endtask

  // Apply this cycle's effects to the model and memory, then cross the clock edge.
  task automatic commit();
    if (bus.instr_ready && exp_q.size() == 0) bubbles++;
    if (bus.pcsrc) begin
      flushes++;
      exp_q.delete();
      m_next = {bus.branch_target[31:2], 2'b00};
      if (m_out) begin
        if (bus.imem_rvalid) begin
          m_out   = 1'b0;
          m_stale = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end
    end else begin
      if (m_pop) void'(exp_q.pop_front());
      if (bus.imem_rvalid && m_out) begin
        if (!m_stale) exp_q.push_back(m_out_pc);
        m_out   = 1'b0;
        m_stale = 1'b0;
      end
      if (m_req) begin
        m_out    = 1'b1;
        m_out_pc = m_next;
        m_next   = m_next + 32'd4;
      end
    end
    if (bus.imem_rvalid) mem_pend = 1'b0;
    if (bus.imem_req) begin
      mem_pend = 1'b1;
      mem_addr = bus.imem_addr;
      mem_due  = cyc + mem_lat;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    bus.instr_ready = 1'b0;
    bus.pcsrc = 1'b0;
    bus.branch_target = 32'h0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    @(posedge clk);
    #1;
    n_vec++;
    if ({bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc, bus.pc_plus8} !==
        {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 32'h8}) begin
      n_err++;
      $display("FAIL reset_outputs got req=%b addr=%h v=%b instr=%h pc=%h p8=%h exp 0 %h 0 0 0 8",
               bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc, bus.pc_plus8, RESET_PC);
    end
    n_vec++;
    if (bus.dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state got=%0d exp=%0d", bus.dbg_state, IDLE);
    end
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    mem_lat = 1;
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      sample();
      n_vec++;
      if (bus.instr_valid !== (exp_q.size() > 0)) begin
        n_err++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", cyc, bus.instr_valid, exp_q.size() > 0);
      end
      n_vec++;
      if (bus.imem_req !== m_req || (m_req && bus.imem_addr !== m_next)) begin
        n_err++; $display("FAIL stream_req cyc=%0d got req=%b addr=%h exp req=%b addr=%h", cyc, bus.imem_req, bus.imem_addr, m_req, m_next);
      end
      if (k == 0) begin
        n_vec++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
          n_err++; $display("FAIL stream_first_req got req=%b addr=%h exp req=1 addr=0", bus.imem_req, bus.imem_addr);
        end
      end
      if (k >= 2) begin
        n_vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4 * (k - 2)) ||
            bus.instr !== (32'(4 * (k - 2)) ^ XOR_K) || bus.pc_plus8 !== 32'(4 * (k - 2) + 8)) begin
          n_err++; $display("FAIL stream_rate cyc=%0d got v=%b pc=%h instr=%h p8=%h exp pc=%h", cyc,
                            bus.instr_valid, bus.instr_pc, bus.instr, bus.pc_plus8, 32'(4 * (k - 2)));
        end
      end
      commit();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_lat = 1;
    for (int k = 0; k < 12; k++) begin
      bus.instr_ready = (k >= 6);
      sample();
      n_vec++;
      if (bus.instr_valid !== (exp_q.size() > 0) || (exp_q.size() > 0 && bus.instr_pc !== exp_q[0])) begin
        n_err++; $display("FAIL bp_head cyc=%0d got v=%b pc=%h exp n=%0d", cyc, bus.instr_valid, bus.instr_pc, exp_q.size());
      end
      n_vec++;
      if (bus.imem_req !== m_req || (m_req && bus.imem_addr !== m_next)) begin
        n_err++; $display("FAIL bp_req cyc=%0d got req=%b addr=%h exp req=%b addr=%h", cyc, bus.imem_req, bus.imem_addr, m_req, m_next);
      end
      if (k >= 3 && k < 6) begin
        n_vec++;
        if (bus.imem_req !== 1'b0) begin
          n_err++; $display("FAIL bp_silent cyc=%0d got req=%b exp req=0", cyc, bus.imem_req);
        end
      end
      if (k >= 2 && k <= 6) begin
        n_vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.instr !== XOR_K) begin
          n_err++; $display("FAIL bp_hold cyc=%0d got v=%b pc=%h instr=%h exp pc=0", cyc, bus.instr_valid, bus.instr_pc, bus.instr);
        end
      end
      if (k == 6) begin
        n_vec++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin
          n_err++; $display("FAIL bp_resume got req=%b addr=%h exp req=1 addr=8", bus.imem_req, bus.imem_addr);
        end
      end
      if (k == 7 || k == 8) begin
        n_vec++;
        if (bus.instr_pc !== 32'(4 * (k - 6))) begin
          n_err++; $display("FAIL bp_drain cyc=%0d got pc=%h exp pc=%h", cyc, bus.instr_pc, 32'(4 * (k - 6)));
        end
      end
      commit();
    end
  endtask

  task automatic test_redirect_outstanding();
    int hit;
    bit got_req;
    bit got_valid;
    hit = -1;
    got_req = 1'b0;
    got_valid = 1'b0;
    do_reset();
    mem_lat = 3;
    bus.instr_ready = 1'b1;
    bus.branch_target = 32'h103;
    for (int k = 0; k < 30; k++) begin
      bus.pcsrc = (hit >= 0) && (k == hit + 1);
      sample();
      n_vec++;
      if (bus.instr_valid !== (exp_q.size() > 0) || (exp_q.size() > 0 && bus.instr_pc !== exp_q[0])) begin
        n_err++; $display("FAIL redir_head cyc=%0d got v=%b pc=%h exp n=%0d", cyc, bus.instr_valid, bus.instr_pc, exp_q.size());
      end
      n_vec++;
      if (bus.imem_req !== m_req || (m_req && bus.imem_addr !== m_next)) begin
        n_err++; $display("FAIL redir_req cyc=%0d got req=%b addr=%h exp req=%b addr=%h", cyc, bus.imem_req, bus.imem_addr, m_req, m_next);
      end
      if (hit >= 0 && k == hit + 2) begin
        n_vec++;
        if (bus.dbg_state !== DROP || bus.instr_valid !== 1'b0) begin
          n_err++; $display("FAIL redir_drop got state=%0d v=%b exp state=%0d v=0", bus.dbg_state, bus.instr_valid, DROP);
        end
      end
      if (hit >= 0 && k > hit + 1 && !got_req && bus.imem_req) begin
        got_req = 1'b1;
        n_vec++;
        if (bus.imem_addr !== 32'h100) begin
          n_err++; $display("FAIL redir_target_addr got=%h exp=00000100", bus.imem_addr);
        end
      end
      if (got_req && !got_valid && bus.instr_valid) begin
        got_valid = 1'b1;
        n_vec++;
        if (bus.instr_pc !== 32'h100) begin
          n_err++; $display("FAIL redir_first_pc got=%h exp=00000100", bus.instr_pc);
        end
      end
      if (hit < 0 && bus.imem_req && bus.imem_addr == 32'h8) hit = k;
      commit();
    end
    bus.pcsrc = 1'b0;
    n_vec++;
    if (hit < 0 || !got_req || !got_valid) begin
      n_err++; $display("FAIL redir_timeout got hit=%0d req=%b valid=%b exp all seen", hit, got_req, got_valid);
    end
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    mem_lat = 1;
    bus.instr_ready = 1'b1;
    bus.branch_target = 32'h40;
    for (int k = 0; k < 11; k++) begin
      bus.pcsrc = (k == 5);
      sample();
      n_vec++;
      if (bus.instr_valid !== (exp_q.size() > 0) || (exp_q.size() > 0 && bus.instr_pc !== exp_q[0])) begin
        n_err++; $display("FAIL coin_head cyc=%0d got v=%b pc=%h exp n=%0d", cyc, bus.instr_valid, bus.instr_pc, exp_q.size());
      end
      n_vec++;
      if (bus.imem_req !== m_req || (m_req && bus.imem_addr !== m_next)) begin
        n_err++; $display("FAIL coin_req cyc=%0d got req=%b addr=%h exp req=%b addr=%h", cyc, bus.imem_req, bus.imem_addr, m_req, m_next);
      end
      if (k == 5) begin
        n_vec++;
        if (bus.imem_rvalid !== 1'b1 || bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
          n_err++; $display("FAIL coin_setup got rvalid=%b v=%b req=%b exp 1 1 0", bus.imem_rvalid, bus.instr_valid, bus.imem_req);
        end
      end
      if (k == 6) begin
        n_vec++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
          n_err++; $display("FAIL coin_after got v=%b req=%b addr=%h exp v=0 req=1 addr=40", bus.instr_valid, bus.imem_req, bus.imem_addr);
        end
      end
      if (k == 8) begin
        n_vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h40) begin
          n_err++; $display("FAIL coin_target got v=%b pc=%h exp v=1 pc=40", bus.instr_valid, bus.instr_pc);
        end
      end
      commit();
    end
    bus.pcsrc = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    mem_lat = 1;
    bus.instr_ready = 1'b1;
    bus.branch_target = 32'hFFFF_FFFE;
    for (int k = 0; k < 10; k++) begin
      bus.pcsrc = (k == 3);
      sample();
      n_vec++;
      if (bus.imem_req !== m_req || (m_req && bus.imem_addr !== m_next)) begin
        n_err++; $display("FAIL wrap_req cyc=%0d got req=%b addr=%h exp req=%b addr=%h", cyc, bus.imem_req, bus.imem_addr, m_req, m_next);
      end
      if (k == 4 || k == 5) begin
        n_vec++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== ((k == 4) ? 32'hFFFF_FFFC : 32'h0)) begin
          n_err++; $display("FAIL wrap_addr cyc=%0d got req=%b addr=%h exp %s", cyc, bus.imem_req, bus.imem_addr, (k == 4) ? "fffffffc" : "00000000");
        end
      end
      if (k == 6) begin
        n_vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'hFFFF_FFFC || bus.pc_plus8 !== 32'h4) begin
          n_err++; $display("FAIL wrap_pc8 got v=%b pc=%h p8=%h exp pc=fffffffc p8=4", bus.instr_valid, bus.instr_pc, bus.pc_plus8);
        end
      end
      if (k == 7) begin
        n_vec++;
        if (bus.instr_pc !== 32'h0 || bus.pc_plus8 !== 32'h8) begin
          n_err++; $display("FAIL wrap_next got pc=%h p8=%h exp pc=0 p8=8", bus.instr_pc, bus.pc_plus8);
        end
      end
      commit();
    end
    bus.pcsrc = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    mem_lat = 3;
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      commit();
    end
    sample();
    n_vec++;
    if (bus.dbg_state !== WAIT || bus.instr_valid !== 1'b1) begin
      n_err++; $display("FAIL midrst_setup got state=%0d v=%b exp state=%0d v=1", bus.dbg_state, bus.instr_valid, WAIT);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc, bus.pc_plus8} !==
        {1'b0, RESET_PC, 1'b0, 32'h0, 32'h0, 32'h8} || bus.dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL midrst_outputs got req=%b addr=%h v=%b instr=%h pc=%h p8=%h st=%0d exp 0 %h 0 0 0 8 IDLE",
               bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc, bus.pc_plus8, bus.dbg_state, RESET_PC);
    end
    do_reset();
    sample();
    n_vec++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
      n_err++; $display("FAIL midrst_first_req got req=%b addr=%h exp req=1 addr=%h", bus.imem_req, bus.imem_addr, RESET_PC);
    end
    commit();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      mem_lat = $urandom_range(1, 3);
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      bus.pcsrc = ($urandom_range(0, 11) == 0);
      bus.branch_target = $urandom;
      sample();
      n_vec++;
      if (bus.instr_valid !== (exp_q.size() > 0)) begin
        n_err++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, bus.instr_valid, exp_q.size() > 0);
      end
      if (exp_q.size() > 0) begin
        n_vec++;
        if (bus.instr_pc !== exp_q[0] || bus.instr !== (exp_q[0] ^ XOR_K) || bus.pc_plus8 !== exp_q[0] + 32'd8) begin
          n_err++; $display("FAIL rnd_head cyc=%0d got pc=%h instr=%h p8=%h exp pc=%h", cyc, bus.instr_pc, bus.instr, bus.pc_plus8, exp_q[0]);
        end
      end
      n_vec++;
      if (bus.imem_req !== m_req || (m_req && bus.imem_addr !== m_next)) begin
        n_err++; $display("FAIL rnd_req cyc=%0d got req=%b addr=%h exp req=%b addr=%h", cyc, bus.imem_req, bus.imem_addr, m_req, m_next);
      end
      commit();
    end
    bus.pcsrc = 1'b0;
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    mem_lat = 2;
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.pcsrc = (k == 3) || (k == 7);
      bus.branch_target = (k == 3) ? 32'h200 : 32'h300;
      sample();
      commit();
    end
    bus.pcsrc = 1'b0;
    n_vec++;
    if (perf_flush_cnt !== 32'd2) begin
      n_err++; $display("FAIL perf_flush got=%0d exp=2", perf_flush_cnt);
    end
    n_vec++;
    if (perf_bubble_cnt !== 32'(bubbles)) begin
      n_err++; $display("FAIL perf_bubble got=%0d exp=%0d", perf_bubble_cnt, bubbles);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_coincident();
    test_wrap();
    test_mid_reset();
    test_random();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit and decoder. It owns the PC, requests instruction words from instruction memory, and buffers them in a small prefetch FIFO.
- Presents Instr[31:0], its PC and PC+8 to decode with a valid/ready handshake.
- Accepts a branch redirect (PCSrc plus target) from the downstream condition logic/ALU and flushes all younger fetched work.

Parameters:
- DEPTH, 2, prefetch FIFO entries (power of two, 2..8).
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  one-cycle request strobe; memory always accepts.
- imem_addr  out  32  word address of request, bits [1:0]=0.
- imem_rvalid  in  1  response strobe, >=1 cycle after imem_req.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- instr_valid  out  1  FIFO head holds an instruction.
- instr_ready  in  1  decode accepts head this cycle.
- instr  out  32  head instruction (drives control unit Instr).
- instr_pc  out  32  address of head instruction.
- pc_plus8  out  32  instr_pc+8, the ARM architectural PC read value.
- pcsrc  in  1  redirect strobe from condition logic.
- branch_target  in  32  redirect address; bits [1:0] ignored and forced to 0.

Behaviour:
- Reset (async, reset=0) sets:
  - pc_q=RESET_PC, state=IDLE, FIFO empty, out_pc_q=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, pc_plus8=8.
- At most one memory request is outstanding. States are IDLE, WAIT and DROP.
- Transitions out of IDLE:
  - If pcsrc=0 and fifo_count(next) < DEPTH: assert imem_req with imem_addr=pc_q, latch out_pc_q=pc_q, pc_q+=4, go to WAIT.
  - Otherwise stay in IDLE.
- Transitions out of WAIT:
  - rvalid and no pcsrc: push {out_pc_q, imem_rdata}. If space remains after push/pop, issue the next request in the same cycle and stay in WAIT; else go to IDLE.
  - No rvalid and no pcsrc: stay in WAIT.
- Transitions out of DROP: on rvalid, discard the data and go to IDLE. No issue is allowed in DROP.
- Redirect (pcsrc=1) has priority over issue, push and pop:
  - Flush the FIFO and set pc_q={branch_target[31:2],2'b00}.
  - WAIT with no rvalid that cycle goes to DROP.
  - WAIT with rvalid that same cycle discards the data and goes to IDLE.
  - IDLE stays IDLE; DROP stays DROP.
  - A pop in the same cycle is cancelled, because the head is younger than the branch.
  - The first request to the target issues on the following cycle at the earliest.
- FIFO:
  - Push and pop may occur in the same cycle, count unchanged. This includes full-with-pop and empty-with-push.
  - Push into an empty FIFO appears on instr_valid the next cycle (registered storage).
  - Pointers wrap modulo DEPTH.
- Latency: imem_req at cycle 0 with rvalid at cycle 1 gives instr_valid at cycle 2. With single-cycle memory the steady-state throughput is 1 instr/cycle.
- Output stability: instr, instr_pc and pc_plus8 are held constant while instr_valid && !instr_ready. instr_valid never drops without a pop or redirect.
- Arithmetic: PC and pc_plus8 arithmetic is modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0 without error.
- pcsrc is sampled every cycle regardless of state; a second redirect in DROP just overwrites pc_q.

Optional Feature:
- FETCH_PERF_EN
- Defined: adds two 32-bit saturating counters, each with an output port:
  - perf_bubble_cnt counts cycles with instr_ready=1 && instr_valid=0.
  - perf_flush_cnt counts pcsrc pulses.
  - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: neither the counters nor the ports exist; behaviour is otherwise identical.

Decomposition:
- fetch_pkg holds:
  - typedef fetch_state_t enum {IDLE, WAIT, DROP}.
  - typedef fetch_entry_t struct {pc[31:0], instr[31:0]}.
  - localparam INSTR_W=32, PC_INC=4, PC_READ_OFS=8.
- Sub-module fetch_fifo (parameter DEPTH, payload fetch_entry_t):
  - Inputs push, pop, flush.
  - Outputs head, count, empty, full.
  - Flush has priority over push and pop.

Test Plan:
- Reset and stream: reset released, 1-cycle memory returning addr^32'hE000_0000, ready=1. Expect:
  - First imem_req cycle 0 addr 0x0.
  - instr_valid from cycle 2 with instr_pc 0x0, 0x4, 0x8…
  - pc_plus8=instr_pc+8.
  - One instruction per cycle.
- Backpressure: ready=0 for 6 cycles. Expect:
  - At most DEPTH=2 entries plus 0 outstanding, imem_req silent once full.
  - Head 0x0 held stable.
  - On ready=1, entries drain in order 0x0, 0x4, then fetch resumes at 0x8.
- Redirect with outstanding request: memory latency 3, pcsrc=1 target 0x103 one cycle after request to 0x8. Expect:
  - FIFO flushed, state DROP.
  - Late response discarded.
  - Next imem_addr=0x100 and first delivered instr_pc=0x100.
- Redirect coincident with rvalid and pop: pcsrc=1 target 0x40 in the same cycle. Expect:
  - Data dropped, pop ignored, instr_valid=0 next cycle.
  - Request to 0x40 the following cycle.
- Wrap and mid-operation reset:
  - Redirect to 0xFFFF_FFFC: next fetch addr 0x0 and pc_plus8=0x4.
  - Assert reset while in WAIT: outputs return to reset values immediately, and the first request after release is to RESET_PC.
- With FETCH_PERF_EN: stream with memory latency 2, ready=1 for 10 cycles, plus 2 redirects. Expect perf_flush_cnt=2 and perf_bubble_cnt equal to the counted empty cycles.
